// File: rtl/shift_add_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_pkg
// Description : Shared types and helpers for the shift-and-add multiplier.
//               - state_t : FSM state encoding (IDLE, BUSY, DONE), 2 bits.
//               - cnt_w   : width of the iteration counter for an N-bit
//                           multiplier ($clog2(N)+1, so N-1 always fits).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc_adder4.sv
`default_nettype none
// ============================================================================
// Module      : rc_adder4
// Description : Parameterised N-bit ripple-carry adder, purely combinational.
//   Ports:
//     a     in  N  addend
//     b     in  N  addend
//     c_in  in  1  carry in
//     s     out N  sum
//     c_out out 1  carry out of the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module rc_adder4 #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);

    // The carry is walked bit by bit through a procedural variable so the
    // chain stays a true ripple without a self-referencing carry vector.
    always_comb begin
        logic w_c;
        w_c = c_in;
        s   = '0;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        c_out = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult
// Description : Sequential unsigned N x N multiplier, shift-and-add method.
//               One partial-product add per cycle through a ripple-carry
//               adder; N busy cycles per product, valid/ready on both sides.
//   Ports:
//     clk       in  1   clock, rising edge
//     rst_n     in  1   asynchronous active-low reset
//     in_valid  in  1   operand pair present
//     in_ready  out 1   block can accept operands (IDLE)
//     a         in  N   multiplicand, unsigned
//     b         in  N   multiplier, unsigned
//     out_valid out 1   product valid (DONE)
//     out_ready in  1   consumer accepts product
//     product   out 2N  a*b, unsigned
//     busy      out 1   high while multiplying (BUSY)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int                c_cnt_w      = cnt_w(N);
    localparam logic [c_cnt_w-1:0] c_count_last = c_cnt_w'(N - 1);

    state_t               r_state;
    logic                 r_started;
    logic [N-1:0]         r_mcand;
    logic [N-1:0]         r_acc_hi;
    logic [N-1:0]         r_acc_lo;
    logic [c_cnt_w-1:0]   r_count;

    logic [N-1:0]         w_sum;
    logic                 w_c_out;

    rc_adder4 #(
        .N (N)
    ) u_adder (
        .a     (r_acc_hi),
        .b     (r_mcand),
        .c_in  (1'b0),
        .s     (w_sum),
        .c_out (w_c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_started <= 1'b0;
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_count   <= '0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_mcand  <= a;
                        r_acc_lo <= b;
                        r_acc_hi <= '0;
                        r_count  <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    // The multiplier bit is consumed from acc_lo[0]; the
                    // adder carry lands in the top bit after the shift, so
                    // the 2N-bit accumulator never overflows.
                    if (r_acc_lo[0]) begin
                        {r_acc_hi, r_acc_lo} <= {w_c_out, w_sum, r_acc_lo[N-1:1]};
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {1'b0, r_acc_hi, r_acc_lo[N-1:1]};
                    end
                    r_count <= r_count + c_cnt_w'(1);
                    if (r_count == c_count_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // State is IDLE while reset is held, yet in_ready must stay low then;
    // r_started keeps it low until the first edge after reset release.
    assign in_ready  = r_started && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == BUSY);
    assign product   = {r_acc_hi, r_acc_lo};

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult
// Description : Self-checking bench for shift_add_mult (N=8). Expected
//               products come from plain integer multiplication; latency,
//               handshake, hold, mid-operation reset and back-to-back
//               spacing are checked against fixed cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    int checks = 0;
    int errors = 0;

    shift_add_mult #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the product is simply the integer product.
    function automatic logic [2*N-1:0] model_mult(input logic [N-1:0] x, input logic [N-1:0] y);
        int unsigned r;
        r = int'(x) * int'(y);
        return r[2*N-1:0];
    endfunction

    // Stimulus only: entered and left on a falling edge. Reports the product
    // and the number of rising edges from the accepting edge to out_valid.
    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y,
                         output logic [2*N-1:0] p, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        p = product;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || product !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got in_ready=%b out_valid=%b busy=%b product=%h, expected all 0",
                     in_ready, out_valid, busy, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got in_ready=%b before first edge, expected 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge: got in_ready=%b busy=%b out_valid=%b, expected 1 0 0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0]   xs[4] = '{8'd13, 8'd255, 8'd0,   8'd200};
        logic [N-1:0]   ys[4] = '{8'd11, 8'd255, 8'd200, 8'd1};
        logic [2*N-1:0] exp_p[4] = '{16'h008F, 16'hFE01, 16'h0000, 16'd200};
        logic [2*N-1:0] p;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(xs[i], ys[i], p, lat);
            checks++;
            if (p !== exp_p[i] || lat != N) begin
                errors++;
                $display("FAIL directed_%0d: got product=%h latency=%0d, expected product=%h latency=%0d",
                         i, p, lat, exp_p[i], N);
            end
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_%0d_idle: got out_valid=%b in_ready=%b, expected 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0]   x, y;
        logic [2*N-1:0] p;
        int lat;
        for (int i = 0; i < 16; i++) begin
            x = N'($urandom);
            y = N'($urandom);
            do_op(x, y, p, lat);
            checks++;
            if (p !== model_mult(x, y) || lat != N) begin
                errors++;
                $display("FAIL random_%0d (%0d*%0d): got product=%0d latency=%0d, expected product=%0d latency=%0d",
                         i, x, y, p, lat, model_mult(x, y), N);
            end
        end
    endtask

    task automatic test_hold();
        logic [2*N-1:0] p;
        int  lat;
        int  w;
        bit  bad;
        a = 8'd100; b = 8'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (product !== 16'd300 || w != N) begin
            errors++;
            $display("FAIL hold_first: got product=%0d latency=%0d, expected 300 latency=%0d", product, w, N);
        end
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin a = 8'd9; b = 8'd9; in_valid = 1'b1; end
            if (k == 3) in_valid = 1'b0;
            @(negedge clk);
            if (product !== 16'd300 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_stable: got product=%0d in_ready=%b out_valid=%b, expected 300 0 1",
                     product, in_ready, out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got out_valid=%b in_ready=%b busy=%b, expected 0 1 0",
                     out_valid, in_ready, busy);
        end
        do_op(8'd9, 8'd9, p, lat);
        checks++;
        if (p !== 16'd81 || lat != N) begin
            errors++;
            $display("FAIL hold_next: got product=%0d latency=%0d, expected 81 latency=%0d", p, lat, N);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*N-1:0] p;
        int lat;
        bit seen;
        a = 8'd77; b = 8'd66; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy: got busy=%b before reset, expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || product !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got in_ready=%b out_valid=%b busy=%b product=%h, expected all 0",
                     in_ready, out_valid, busy, product);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_no_valid: got out_valid=1 after reset, expected 0");
        end
        do_op(8'd7, 8'd9, p, lat);
        checks++;
        if (p !== 16'd63 || lat != N) begin
            errors++;
            $display("FAIL midreset_after: got product=%0d latency=%0d, expected 63 latency=%0d", p, lat, N);
        end
    endtask

    task automatic test_back_to_back();
        int             acc_cyc[$];
        logic [2*N-1:0] prods[$];
        int             n_acc;
        bit             accept;
        n_acc = 0;
        a = 8'd5; b = 8'd6; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) prods.push_back(product);
            accept = in_ready && in_valid;
            if (accept) acc_cyc.push_back(k);
            @(negedge clk);
            if (accept) begin
                n_acc++;
                if (n_acc == 1) begin a = 8'd12; b = 8'd12; end
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (acc_cyc.size() != 2 || (acc_cyc.size() == 2 && acc_cyc[1] - acc_cyc[0] != N + 2)) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d accepts, gap=%0d, expected 2 accepts gap=%0d",
                     acc_cyc.size(), (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1, N + 2);
        end
        checks++;
        if (prods.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d products, expected 2", prods.size());
        end else if (prods[0] !== model_mult(8'd5, 8'd6) || prods[1] !== model_mult(8'd12, 8'd12)) begin
            errors++;
            $display("FAIL b2b_values: got %0d then %0d, expected 30 then 144", prods[0], prods[1]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
